// File: rtl/snes_autojoy.sv
// Controller port engine: auto-joypad read at vblank plus manual CPU latch/clock pass-through.
// Define AUTOJOY_MULTITAP_EN to sample the D1 lines into JOY3/JOY4; otherwise those read zero.
module snes_autojoy #(
  parameter int LATCH_TICKS = 12,
  parameter int HALF_TICKS  = 12
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        AUTO_EN,
  input  logic        VBLANK_START,
  input  logic        CPU_LATCH,
  input  logic        CPU_RD0,
  input  logic        CPU_RD1,
  input  logic [1:0]  PORT0_DI,
  input  logic [1:0]  PORT1_DI,
  output logic        PORT_LATCH,
  output logic        PORT0_CLK,
  output logic        PORT1_CLK,
  output logic [15:0] JOY1,
  output logic [15:0] JOY2,
  output logic [15:0] JOY3,
  output logic [15:0] JOY4,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SAMPLE, S_CLK_LO, S_CLK_HI, S_COMMIT
  } state_t;

  localparam logic [7:0] LAST_LATCH = 8'(LATCH_TICKS - 1);
  localparam logic [7:0] LAST_HALF  = 8'(HALF_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic [3:0]  bit_q, bit_d;
  logic        auto_latch_q, auto_latch_d;
  logic        auto_clk_q, auto_clk_d;
  logic        busy_q, busy_d;
  logic        port_latch_q, port_latch_d;
  logic        port0_clk_q, port0_clk_d;
  logic        port1_clk_q, port1_clk_d;
  logic [15:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [15:0] joy1_q, joy1_d, joy2_q, joy2_d;
`ifdef AUTOJOY_MULTITAP_EN
  logic [15:0] sh3_q, sh3_d, sh4_q, sh4_d;
  logic [15:0] joy3_q, joy3_d, joy4_q, joy4_d;
`else
  logic        unused_d1;
  assign unused_d1 = ^{PORT0_DI[1], PORT1_DI[1]};
`endif

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    auto_latch_d = auto_latch_q;
    auto_clk_d   = auto_clk_q;
    busy_d       = busy_q;
    sh1_d        = sh1_q;
    sh2_d        = sh2_q;
    joy1_d       = joy1_q;
    joy2_d       = joy2_q;
`ifdef AUTOJOY_MULTITAP_EN
    sh3_d        = sh3_q;
    sh4_d        = sh4_q;
    joy3_d       = joy3_q;
    joy4_d       = joy4_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (CE && VBLANK_START && AUTO_EN) begin
          state_d      = S_LATCH;
          busy_d       = 1'b1;
          auto_latch_d = 1'b1;
          tick_d       = 8'd0;
          sh1_d        = 16'h0000;
          sh2_d        = 16'h0000;
`ifdef AUTOJOY_MULTITAP_EN
          sh3_d        = 16'h0000;
          sh4_d        = 16'h0000;
`endif
        end
      end
      S_LATCH: begin
        if (CE) begin
          if (tick_q == LAST_LATCH) begin
            state_d      = S_SAMPLE;
            tick_d       = 8'd0;
            bit_d        = 4'd0;
            auto_latch_d = 1'b0;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      S_SAMPLE: begin
        // Pad data is active-low; store 1 = pressed, first bit ends up in the MSB.
        if (CE) begin
          sh1_d      = {sh1_q[14:0], ~PORT0_DI[0]};
          sh2_d      = {sh2_q[14:0], ~PORT1_DI[0]};
`ifdef AUTOJOY_MULTITAP_EN
          sh3_d      = {sh3_q[14:0], ~PORT0_DI[1]};
          sh4_d      = {sh4_q[14:0], ~PORT1_DI[1]};
`endif
          auto_clk_d = 1'b0;
          state_d    = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        if (CE) begin
          if (tick_q == LAST_HALF) begin
            state_d    = S_CLK_HI;
            tick_d     = 8'd0;
            auto_clk_d = 1'b1;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      S_CLK_HI: begin
        if (CE) begin
          if (tick_q == LAST_HALF) begin
            tick_d = 8'd0;
            if (bit_q == 4'd15) begin
              state_d = S_COMMIT;
            end else begin
              bit_d   = bit_q + 4'd1;
              state_d = S_SAMPLE;
            end
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      S_COMMIT: begin
        // All result registers update together so software never sees a mixed frame.
        joy1_d  = sh1_q;
        joy2_d  = sh2_q;
`ifdef AUTOJOY_MULTITAP_EN
        joy3_d  = sh3_q;
        joy4_d  = sh4_q;
`endif
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    port_latch_d = auto_latch_d | CPU_LATCH;
    port0_clk_d  = auto_clk_d & ~CPU_RD0;
    port1_clk_d  = auto_clk_d & ~CPU_RD1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      tick_q       <= 8'd0;
      bit_q        <= 4'd0;
      auto_latch_q <= 1'b0;
      auto_clk_q   <= 1'b1;
      busy_q       <= 1'b0;
      port_latch_q <= 1'b0;
      port0_clk_q  <= 1'b1;
      port1_clk_q  <= 1'b1;
      sh1_q        <= 16'h0000;
      sh2_q        <= 16'h0000;
      joy1_q       <= 16'h0000;
      joy2_q       <= 16'h0000;
`ifdef AUTOJOY_MULTITAP_EN
      sh3_q        <= 16'h0000;
      sh4_q        <= 16'h0000;
      joy3_q       <= 16'h0000;
      joy4_q       <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      auto_latch_q <= auto_latch_d;
      auto_clk_q   <= auto_clk_d;
      busy_q       <= busy_d;
      port_latch_q <= port_latch_d;
      port0_clk_q  <= port0_clk_d;
      port1_clk_q  <= port1_clk_d;
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
      joy1_q       <= joy1_d;
      joy2_q       <= joy2_d;
`ifdef AUTOJOY_MULTITAP_EN
      sh3_q        <= sh3_d;
      sh4_q        <= sh4_d;
      joy3_q       <= joy3_d;
      joy4_q       <= joy4_d;
`endif
    end
  end

  assign PORT_LATCH = port_latch_q;
  assign PORT0_CLK  = port0_clk_q;
  assign PORT1_CLK  = port1_clk_q;
  assign BUSY       = busy_q;
  assign JOY1       = joy1_q;
  assign JOY2       = joy2_q;
`ifdef AUTOJOY_MULTITAP_EN
  assign JOY3       = joy3_q;
  assign JOY4       = joy4_q;
`else
  assign JOY3       = 16'h0000;
  assign JOY4       = 16'h0000;
`endif

endmodule
